sprite_motion_ctrl: RTL and testbench

- Per-frame position controller for the single green rectangle drawn by the VGA pixel stage (640x480 @ 25 MHz pixel, 800x521 total).
- Sits directly upstream of the VGA driver and supplies its up/down/left/right position registers.
- On each frame-start strobe it advances the box by a programmable step, bounces off the active-area bounds and commits all four edges atomically, so the scan never sees a half-updated box.

---
 rtl/sprite_motion_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Per-frame position controller for the green box drawn by the VGA pixel
//   stage. On an accepted frame_tick it computes new horizontal bounds
//   (CALC_H), then vertical bounds (CALC_V), and commits all four edges,
//   both directions and the bounce pulses in one cycle (COMMIT). Until then
//   the scan keeps seeing the previous box.
//
//   Optional build macro: FRAME_SKIP_EN
//     When defined, only every FRAME_DIV-th accepted frame_tick moves the box.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   frame_tick         one-clk frame-start strobe
//   run                0 freezes motion
//   step_h, step_v     pixels / lines per move (0..7)
//   dir_load           load dir_h_in / dir_v_in (IDLE only)
//   dir_h_in, dir_v_in 1 = right / down
//   left_pos..down_pos inclusive box bounds
//   dir_h, dir_v       committed direction
//   bounce_h, bounce_v one-clk pulse with a committed bounce
//   update_done        one-clk pulse when new values first appear
//   overrun            sticky: frame_tick arrived while busy
module sprite_motion_ctrl #(
  parameter int H_MIN     = 144,
  parameter int H_MAX     = 783,
  parameter int V_MIN     = 31,
  parameter int V_MAX     = 510,
  parameter int BOX_W     = 160,
  parameter int BOX_H     = 120,
  parameter int INIT_LEFT = 384,
  parameter int INIT_UP   = 391
`ifdef FRAME_SKIP_EN
  ,
  parameter int FRAME_DIV = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [2:0] step_h,
  input  logic [2:0] step_v,
  input  logic       dir_load,
  input  logic       dir_h_in,
  input  logic       dir_v_in,
  output logic [9:0] left_pos,
  output logic [9:0] right_pos,
  output logic [9:0] up_pos,
  output logic [9:0] down_pos,
  output logic       dir_h,
  output logic       dir_v,
  output logic       bounce_h,
  output logic       bounce_v,
  output logic       update_done,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, CALC_H, CALC_V, COMMIT} state_t;

  localparam logic [10:0] HMIN_11 = 11'(H_MIN);
  localparam logic [10:0] HMAX_11 = 11'(H_MAX);
  localparam logic [10:0] VMIN_11 = 11'(V_MIN);
  localparam logic [10:0] VMAX_11 = 11'(V_MAX);

  localparam logic [9:0] H_LO_L = 10'(H_MIN);
  localparam logic [9:0] H_LO_R = 10'(H_MIN + BOX_W - 1);
  localparam logic [9:0] H_HI_L = 10'(H_MAX - BOX_W + 1);
  localparam logic [9:0] H_HI_R = 10'(H_MAX);
  localparam logic [9:0] V_LO_U = 10'(V_MIN);
  localparam logic [9:0] V_LO_D = 10'(V_MIN + BOX_H - 1);
  localparam logic [9:0] V_HI_U = 10'(V_MAX - BOX_H + 1);
  localparam logic [9:0] V_HI_D = 10'(V_MAX);

  localparam logic [9:0] RST_L = 10'(INIT_LEFT);
  localparam logic [9:0] RST_R = 10'(INIT_LEFT + BOX_W - 1);
  localparam logic [9:0] RST_U = 10'(INIT_UP);
  localparam logic [9:0] RST_D = 10'(INIT_UP + BOX_H - 1);

`ifdef FRAME_SKIP_EN
  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  logic [CNT_W-1:0] r_frame_cnt;
`endif

  state_t     r_state;
  // Working directions: loaded by dir_load and advanced during the calc
  // states; the dir_h/dir_v outputs only follow them at COMMIT.
  logic       r_dir_h;
  logic       r_dir_v;
  logic [9:0] r_left_nx;
  logic [9:0] r_right_nx;
  logic [9:0] r_up_nx;
  logic [9:0] r_down_nx;
  logic       r_bh_nx;
  logic       r_bv_nx;

  logic [10:0] w_r_cand;
  logic [10:0] w_l_lim;
  logic [10:0] w_d_cand;
  logic [10:0] w_u_lim;
  logic [9:0]  w_left_h;
  logic [9:0]  w_right_h;
  logic [9:0]  w_up_v;
  logic [9:0]  w_down_v;
  logic        w_bh;
  logic        w_bv;

  // Horizontal candidate; the "<= MIN+step" test keeps left_pos-step from
  // ever going below the bound, so the subtraction cannot wrap.
  always_comb begin
    w_r_cand  = {1'b0, right_pos} + {8'b0, step_h};
    w_l_lim   = HMIN_11 + {8'b0, step_h};
    w_bh      = 1'b0;
    w_left_h  = left_pos;
    w_right_h = right_pos;
    if (r_dir_h) begin
      if (w_r_cand >= HMAX_11) begin
        w_bh      = 1'b1;
        w_left_h  = H_HI_L;
        w_right_h = H_HI_R;
      end else begin
        w_left_h  = left_pos + {7'b0, step_h};
        w_right_h = w_r_cand[9:0];
      end
    end else begin
      if ({1'b0, left_pos} <= w_l_lim) begin
        w_bh      = 1'b1;
        w_left_h  = H_LO_L;
        w_right_h = H_LO_R;
      end else begin
        w_left_h  = left_pos - {7'b0, step_h};
        w_right_h = right_pos - {7'b0, step_h};
      end
    end
  end

  always_comb begin
    w_d_cand = {1'b0, down_pos} + {8'b0, step_v};
    w_u_lim  = VMIN_11 + {8'b0, step_v};
    w_bv     = 1'b0;
    w_up_v   = up_pos;
    w_down_v = down_pos;
    if (r_dir_v) begin
      if (w_d_cand >= VMAX_11) begin
        w_bv     = 1'b1;
        w_up_v   = V_HI_U;
        w_down_v = V_HI_D;
      end else begin
        w_up_v   = up_pos + {7'b0, step_v};
        w_down_v = w_d_cand[9:0];
      end
    end else begin
      if ({1'b0, up_pos} <= w_u_lim) begin
        w_bv     = 1'b1;
        w_up_v   = V_LO_U;
        w_down_v = V_LO_D;
      end else begin
        w_up_v   = up_pos - {7'b0, step_v};
        w_down_v = down_pos - {7'b0, step_v};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dir_h     <= 1'b1;
      r_dir_v     <= 1'b0;
      r_left_nx   <= RST_L;
      r_right_nx  <= RST_R;
      r_up_nx     <= RST_U;
      r_down_nx   <= RST_D;
      r_bh_nx     <= 1'b0;
      r_bv_nx     <= 1'b0;
      left_pos    <= RST_L;
      right_pos   <= RST_R;
      up_pos      <= RST_U;
      down_pos    <= RST_D;
      dir_h       <= 1'b1;
      dir_v       <= 1'b0;
      bounce_h    <= 1'b0;
      bounce_v    <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
`ifdef FRAME_SKIP_EN
      r_frame_cnt <= '0;
`endif
    end else begin
      bounce_h    <= 1'b0;
      bounce_v    <= 1'b0;
      update_done <= 1'b0;

      if (frame_tick && run && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end

`ifdef FRAME_SKIP_EN
      if (!run) begin
        r_frame_cnt <= '0;
      end
`endif

      case (r_state)
        IDLE: begin
          if (dir_load) begin
            r_dir_h <= dir_h_in;
            r_dir_v <= dir_v_in;
          end
          if (frame_tick && run) begin
`ifdef FRAME_SKIP_EN
            if (r_frame_cnt == CNT_LAST) begin
              r_frame_cnt <= '0;
              r_state     <= CALC_H;
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
`else
            r_state <= CALC_H;
`endif
          end
        end
        CALC_H: begin
          r_left_nx  <= w_left_h;
          r_right_nx <= w_right_h;
          r_bh_nx    <= w_bh;
          r_dir_h    <= r_dir_h ^ w_bh;
          r_state    <= CALC_V;
        end
        CALC_V: begin
          r_up_nx   <= w_up_v;
          r_down_nx <= w_down_v;
          r_bv_nx   <= w_bv;
          r_dir_v   <= r_dir_v ^ w_bv;
          r_state   <= COMMIT;
        end
        COMMIT: begin
          left_pos    <= r_left_nx;
          right_pos   <= r_right_nx;
          up_pos      <= r_up_nx;
          down_pos    <= r_down_nx;
          dir_h       <= r_dir_h;
          dir_v       <= r_dir_v;
          bounce_h    <= r_bh_nx;
          bounce_v    <= r_bv_nx;
          update_done <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: table of per-frame vectors with
// hand-computed results plus directed sequences for bounces, overrun, run=0,
// reset during an update and (when FRAME_SKIP_EN is defined) frame skipping.
module tb_sprite_motion_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       run;
  logic [2:0] step_h;
  logic [2:0] step_v;
  logic       dir_load;
  logic       dir_h_in;
  logic       dir_v_in;
  logic [9:0] left_pos;
  logic [9:0] right_pos;
  logic [9:0] up_pos;
  logic [9:0] down_pos;
  logic       dir_h;
  logic       dir_v;
  logic       bounce_h;
  logic       bounce_v;
  logic       update_done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .run        (run),
    .step_h     (step_h),
    .step_v     (step_v),
    .dir_load   (dir_load),
    .dir_h_in   (dir_h_in),
    .dir_v_in   (dir_v_in),
    .left_pos   (left_pos),
    .right_pos  (right_pos),
    .up_pos     (up_pos),
    .down_pos   (down_pos),
    .dir_h      (dir_h),
    .dir_v      (dir_v),
    .bounce_h   (bounce_h),
    .bounce_v   (bounce_v),
    .update_done(update_done),
    .overrun    (overrun)
  );

  typedef struct {
    logic       ld;
    logic       dhi;
    logic       dvi;
    logic [2:0] sh;
    logic [2:0] sv;
    int         l;
    int         r;
    int         u;
    int         d;
    logic       dh;
    logic       dv;
    logic       bh;
    logic       bv;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    frame_tick = 1'b0;
    dir_load   = 1'b0;
    dir_h_in   = 1'b0;
    dir_v_in   = 1'b0;
    run        = 1'b1;
    step_h     = 3'd0;
    step_v     = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // With frame skipping, issue the ticks that only advance the counter.
  task automatic prime();
`ifdef FRAME_SKIP_EN
    repeat (DIV - 1) begin
      pulse_tick();
      repeat (2) @(negedge clk);
    end
`endif
  endtask

  task automatic wait_done(output int lat, output logic bh, output logic bv);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!update_done && i < 12);
    lat = update_done ? i : 0;
    bh  = bounce_h;
    bv  = bounce_v;
  endtask

  task automatic do_frame(input logic ld, input logic dhi, input logic dvi,
                          output logic bh, output logic bv);
    int lat;
    prime();
    @(negedge clk);
    frame_tick = 1'b1;
    dir_load   = ld;
    dir_h_in   = dhi;
    dir_v_in   = dvi;
    @(negedge clk);
    frame_tick = 1'b0;
    dir_load   = 1'b0;
    wait_done(lat, bh, bv);
    chk("latency", lat, 3);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (update_done) cnt++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bh, bv;
    int   nb, cnt, lat;
    logic pulse_seen;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 3'd7, 3'd5, 395, 554, 386, 505, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 3'd3, 3'd2, 392, 551, 388, 507, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 392, 551, 391, 510, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 392, 551, 391, 510, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 3'd6, 3'd4, 386, 545, 387, 506, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 387, 546, 388, 507, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state held through 100 idle cycles.
    do_reset();
    pulse_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bounce_h || bounce_v || update_done) pulse_seen = 1'b1;
    end
    chk("idle_pulses", pulse_seen, 0);
    chk("rst_left", left_pos, 384);
    chk("rst_right", right_pos, 543);
    chk("rst_up", up_pos, 391);
    chk("rst_down", down_pos, 510);
    chk("rst_dir_h", dir_h, 1);
    chk("rst_dir_v", dir_v, 0);
    chk("rst_overrun", overrun, 0);

    // First move, with the hold-until-commit timing checked cycle by cycle.
    step_h = 3'd4;
    step_v = 3'd0;
    prime();
    pulse_tick();
    @(negedge clk);
    chk("hold1_left", left_pos, 384);
    chk("hold1_done", update_done, 0);
    @(negedge clk);
    chk("hold2_left", left_pos, 384);
    chk("hold2_done", update_done, 0);
    @(negedge clk);
    chk("mv_done", update_done, 1);
    chk("mv_left", left_pos, 388);
    chk("mv_right", right_pos, 547);
    chk("mv_up", up_pos, 391);
    chk("mv_down", down_pos, 510);
    chk("mv_bh", bounce_h, 0);
    @(negedge clk);
    chk("mv_done_1clk", update_done, 0);

    // Table-driven frames continuing from left=388.
    for (int k = 0; k < 6; k++) begin
      step_h = tbl[k].sh;
      step_v = tbl[k].sv;
      do_frame(tbl[k].ld, tbl[k].dhi, tbl[k].dvi, bh, bv);
      chk($sformatf("tbl%0d_left", k), left_pos, tbl[k].l);
      chk($sformatf("tbl%0d_right", k), right_pos, tbl[k].r);
      chk($sformatf("tbl%0d_up", k), up_pos, tbl[k].u);
      chk($sformatf("tbl%0d_down", k), down_pos, tbl[k].d);
      chk($sformatf("tbl%0d_dir_h", k), dir_h, tbl[k].dh);
      chk($sformatf("tbl%0d_dir_v", k), dir_v, tbl[k].dv);
      chk($sformatf("tbl%0d_bh", k), bh, tbl[k].bh);
      chk($sformatf("tbl%0d_bv", k), bv, tbl[k].bv);
    end

    // Right bound: 35 frames of step 7.
    do_reset();
    step_h = 3'd7;
    nb = 0;
    for (int f = 1; f <= 34; f++) begin
      do_frame(1'b0, 1'b0, 1'b0, bh, bv);
      if (bh) nb++;
    end
    chk("r34_right", right_pos, 781);
    chk("r34_left", left_pos, 622);
    do_frame(1'b0, 1'b0, 1'b0, bh, bv);
    if (bh) nb++;
    chk("r35_right", right_pos, 783);
    chk("r35_left", left_pos, 624);
    chk("r35_dir_h", dir_h, 0);
    chk("r35_bh", bh, 1);
    chk("r_bounce_count", nb, 1);
    // Step 0 while touching the bound it moves toward: flip only.
    step_h = 3'd0;
    do_frame(1'b1, 1'b1, 1'b0, bh, bv);
    chk("s0_right", right_pos, 783);
    chk("s0_left", left_pos, 624);
    chk("s0_dir_h", dir_h, 0);
    chk("s0_bh", bh, 1);

    // Left bound: load left on the first frame, step 7.
    do_reset();
    step_h = 3'd7;
    nb = 0;
    do_frame(1'b1, 1'b0, 1'b0, bh, bv);
    chk("l1_left", left_pos, 377);
    for (int f = 2; f <= 34; f++) begin
      do_frame(1'b0, 1'b0, 1'b0, bh, bv);
      if (bh) nb++;
    end
    chk("l34_left", left_pos, 146);
    do_frame(1'b0, 1'b0, 1'b0, bh, bv);
    if (bh) nb++;
    chk("l35_left", left_pos, 144);
    chk("l35_right", right_pos, 303);
    chk("l35_dir_h", dir_h, 1);
    chk("l_bounce_count", nb, 1);

    // Upper bound: step_v=5, equality at frame 72.
    do_reset();
    step_v = 3'd5;
    nb = 0;
    for (int f = 1; f <= 71; f++) begin
      do_frame(1'b0, 1'b0, 1'b0, bh, bv);
      if (bv) nb++;
    end
    chk("u71_up", up_pos, 36);
    do_frame(1'b0, 1'b0, 1'b0, bh, bv);
    if (bv) nb++;
    chk("u72_up", up_pos, 31);
    chk("u72_down", down_pos, 150);
    chk("u72_dir_v", dir_v, 1);
    chk("u72_bv", bv, 1);
    chk("u_bounce_count", nb, 1);
    chk("u72_left", left_pos, 384);
    do_frame(1'b0, 1'b0, 1'b0, bh, bv);
    chk("u73_up", up_pos, 36);
    chk("u73_down", down_pos, 155);
    chk("u73_bv", bv, 0);

    // run=0: tick ignored, no overrun.
    do_reset();
    run = 1'b0;
    step_h = 3'd2;
    pulse_tick();
    count_done(10, cnt);
    chk("run0_updates", cnt, 0);
    chk("run0_left", left_pos, 384);
    chk("run0_overrun", overrun, 0);

    // Overrun: second tick while the update is in flight.
    run = 1'b1;
    prime();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_done(lat, bh, bv);
    chk("ovr_latency", lat, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_left", left_pos, 386);
    count_done(12, cnt);
    chk("ovr_extra_updates", cnt, 0);
    chk("ovr_left_after", left_pos, 386);
    do_frame(1'b0, 1'b0, 1'b0, bh, bv);
    chk("ovr_sticky", overrun, 1);

    // Reset asserted while the FSM is in CALC_V.
    do_reset();
    step_h = 3'd4;
    step_v = 3'd3;
    do_frame(1'b0, 1'b0, 1'b0, bh, bv);
    chk("pre_rst_left", left_pos, 388);
    prime();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_left_now", left_pos, 384);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_done(10, cnt);
    chk("abort_updates", cnt, 0);
    chk("abort_left", left_pos, 384);
    chk("abort_right", right_pos, 543);
    chk("abort_up", up_pos, 391);
    chk("abort_down", down_pos, 510);
    chk("abort_dir_h", dir_h, 1);

`ifdef FRAME_SKIP_EN
    do_reset();
    step_h = 3'd1;
    cnt = 0;
    repeat (8) begin
      pulse_tick();
      count_done(6, nb);
      cnt += nb;
    end
    chk("skip_updates", cnt, 2);
    chk("skip_left", left_pos, 386);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
